// File: rtl/ex_stage_exmem.sv
// Execute stage of the 5-stage MIPS-subset pipeline, including the EX/MEM register.
// Resolves RAW hazards by forwarding and stalls the front end during the iterative multiply.
module ex_stage_exmem #(
  parameter int W       = 32,
  parameter int MUL_CYC = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rg1,
  input  logic [W-1:0] rg2,
  input  logic [W-1:0] immVal,
  input  logic [4:0]   destReg,
  input  logic [4:0]   rdRg1,
  input  logic [4:0]   rdRg2,
  input  logic [1:0]   AluOp,
  input  logic         AluSrc,
  input  logic         RegDst,
  input  logic         MemWr,
  input  logic         MemRd,
  input  logic         DataSrc,
  input  logic         WrReg,
  input  logic         wb_wr,
  input  logic [4:0]   wb_dst,
  input  logic [W-1:0] wb_data,
  output logic [W-1:0] alu_res,
  output logic [W-1:0] st_data,
  output logic [4:0]   dst,
  output logic         zero,
  output logic         mem_wr,
  output logic         mem_rd,
  output logic         data_src,
  output logic         wr_reg,
  output logic         stall_o
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_MULT = 6'b011000;

  localparam int CNT_W = $clog2(MUL_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_CYC - 1);

  state_t state, state_nxt;

  logic [5:0]       funct;
  logic             is_mult;
  logic [W-1:0]     op_a, fwd_b, op_b, alu_out;
  logic [4:0]       dst_sel;

  logic [W-1:0]     mcand, mplier, acc, m_st;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       m_dst;
  logic             m_memwr, m_memrd, m_datasrc, m_wrreg;

  assign funct   = immVal[5:0];
  assign is_mult = (AluOp == 2'b10) && (funct == F_MULT);
  assign dst_sel = RegDst ? destReg : rdRg2;

  // EX/MEM wins over MEM/WB because it holds the younger result; r0 never forwards.
  always_comb begin
    op_a  = rg1;
    fwd_b = rg2;
    if (wr_reg && dst != 5'd0 && dst == rdRg1)
      op_a = alu_res;
    else if (wb_wr && wb_dst != 5'd0 && wb_dst == rdRg1)
      op_a = wb_data;
    if (wr_reg && dst != 5'd0 && dst == rdRg2)
      fwd_b = alu_res;
    else if (wb_wr && wb_dst != 5'd0 && wb_dst == rdRg2)
      fwd_b = wb_data;
  end

  assign op_b = AluSrc ? immVal : fwd_b;

  always_comb begin
    alu_out = '0;
    case (AluOp)
      2'b00: alu_out = op_a + op_b;
      2'b01: alu_out = op_a - op_b;
      2'b11: alu_out = op_a | op_b;
      default: begin
        case (funct)
          F_ADD:   alu_out = op_a + op_b;
          F_SUB:   alu_out = op_a - op_b;
          F_AND:   alu_out = op_a & op_b;
          F_OR:    alu_out = op_a | op_b;
          F_SLT:   alu_out = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
          default: alu_out = '0;
        endcase
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        if (is_mult) begin
          state_nxt = MUL;
          stall_o   = 1'b1;
        end
      end
      MUL: begin
        stall_o = 1'b1;
        if (cnt == LAST_STEP)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst)
      stall_o = 1'b0;
  end

  // Operands and the mult's destination/controls are latched at capture so MEM/WB draining cannot disturb them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      m_st      <= '0;
      m_dst     <= 5'd0;
      m_memwr   <= 1'b0;
      m_memrd   <= 1'b0;
      m_datasrc <= 1'b0;
      m_wrreg   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (is_mult) begin
            mcand     <= op_a;
            mplier    <= op_b;
            acc       <= '0;
            cnt       <= '0;
            m_st      <= fwd_b;
            m_dst     <= dst_sel;
            m_memwr   <= MemWr;
            m_memrd   <= MemRd;
            m_datasrc <= DataSrc;
            m_wrreg   <= WrReg;
          end
        end
        MUL: begin
          acc    <= acc + (mplier[0] ? mcand : '0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_res  <= '0;
      st_data  <= '0;
      dst      <= 5'd0;
      zero     <= 1'b0;
      mem_wr   <= 1'b0;
      mem_rd   <= 1'b0;
      data_src <= 1'b0;
      wr_reg   <= 1'b0;
    end else if (state == DONE) begin
      alu_res  <= acc;
      st_data  <= m_st;
      dst      <= m_dst;
      zero     <= (acc == '0);
      mem_wr   <= m_memwr;
      mem_rd   <= m_memrd;
      data_src <= m_datasrc;
      wr_reg   <= m_wrreg;
    end else if (stall_o) begin
      alu_res  <= '0;
      st_data  <= '0;
      dst      <= 5'd0;
      zero     <= 1'b0;
      mem_wr   <= 1'b0;
      mem_rd   <= 1'b0;
      data_src <= 1'b0;
      wr_reg   <= 1'b0;
    end else begin
      alu_res  <= alu_out;
      st_data  <= fwd_b;
      dst      <= dst_sel;
      zero     <= (alu_out == '0);
      mem_wr   <= MemWr;
      mem_rd   <= MemRd;
      data_src <= DataSrc;
      wr_reg   <= WrReg;
    end
  end

endmodule

// File: tb/tb_ex_stage_exmem.sv
// Directed bench for ex_stage_exmem: table of single-cycle ops with forwarding,
// then hand-written multiply, back-to-back multiply and reset-abort sequences.
module tb_ex_stage_exmem;

  localparam int W = 32;

  typedef struct {
    logic [31:0] rg1, rg2, imm;
    logic [4:0]  destReg, rs, rt;
    logic [1:0]  aluOp;
    logic        aluSrc, regDst;
    logic [3:0]  ctrl;
    logic        wbWr;
    logic [4:0]  wbDst;
    logic [31:0] wbData;
    logic [31:0] expRes, expSt;
    logic [4:0]  expDst;
    logic        expZero;
    logic [3:0]  expCtrl;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] rg1, rg2, immVal, wb_data, alu_res, st_data;
  logic [4:0]   destReg, rdRg1, rdRg2, wb_dst, dst;
  logic [1:0]   AluOp;
  logic         AluSrc, RegDst, MemWr, MemRd, DataSrc, WrReg, wb_wr;
  logic         zero, mem_wr, mem_rd, data_src, wr_reg, stall_o;

  int passCount  = 0;
  int checkCount = 0;
  vec_t vecs[15];

  always #5 clk = ~clk;

  ex_stage_exmem #(.W(W), .MUL_CYC(32)) dut (
    .clk(clk), .rst(rst), .rg1(rg1), .rg2(rg2), .immVal(immVal),
    .destReg(destReg), .rdRg1(rdRg1), .rdRg2(rdRg2), .AluOp(AluOp),
    .AluSrc(AluSrc), .RegDst(RegDst), .MemWr(MemWr), .MemRd(MemRd),
    .DataSrc(DataSrc), .WrReg(WrReg), .wb_wr(wb_wr), .wb_dst(wb_dst),
    .wb_data(wb_data), .alu_res(alu_res), .st_data(st_data), .dst(dst),
    .zero(zero), .mem_wr(mem_wr), .mem_rd(mem_rd), .data_src(data_src),
    .wr_reg(wr_reg), .stall_o(stall_o)
  );

  function automatic vec_t mk(
    input logic [31:0] a, b, imm, input logic [4:0] dreg, rs, rt,
    input logic [1:0] op, input logic src, rdst, input logic [3:0] ctrl,
    input logic wbw, input logic [4:0] wbd, input logic [31:0] wbv,
    input logic [31:0] eres, est, input logic [4:0] edst, input logic ez,
    input logic [3:0] ectrl);
    vec_t v;
    v.rg1 = a;  v.rg2 = b;  v.imm = imm;  v.destReg = dreg;  v.rs = rs;  v.rt = rt;
    v.aluOp = op;  v.aluSrc = src;  v.regDst = rdst;  v.ctrl = ctrl;
    v.wbWr = wbw;  v.wbDst = wbd;  v.wbData = wbv;
    v.expRes = eres;  v.expSt = est;  v.expDst = edst;  v.expZero = ez;  v.expCtrl = ectrl;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    rg1 = v.rg1;  rg2 = v.rg2;  immVal = v.imm;
    destReg = v.destReg;  rdRg1 = v.rs;  rdRg2 = v.rt;
    AluOp = v.aluOp;  AluSrc = v.aluSrc;  RegDst = v.regDst;
    {MemWr, MemRd, DataSrc, WrReg} = v.ctrl;
    wb_wr = v.wbWr;  wb_dst = v.wbDst;  wb_data = v.wbData;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkVal({tag, " alu_res"}, alu_res, v.expRes);
    checkVal({tag, " st_data"}, st_data, v.expSt);
    checkVal({tag, " dst"}, 32'(dst), 32'(v.expDst));
    checkVal({tag, " zero"}, 32'(zero), 32'(v.expZero));
    checkVal({tag, " ctrl"}, 32'({mem_wr, mem_rd, data_src, wr_reg}), 32'(v.expCtrl));
  endtask

  // Called in the cycle a mult was presented; returns one cycle into DONE.
  task automatic runMult(input string tag, input logic [4:0] rsIdx);
    int stalls = 1;
    int bubbleBad = 0;
    for (int e = 1; e <= 33; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        wb_wr = 1'b1;  wb_dst = rsIdx;  wb_data = 32'h0000_0999;
      end
      if (stall_o) stalls++;
      if (alu_res !== '0 || dst !== 5'd0 || {mem_wr, mem_rd, data_src, wr_reg} !== 4'b0)
        bubbleBad++;
    end
    wb_wr = 1'b0;
    checkVal({tag, " stall cycles"}, 32'(stalls), 32'd33);
    checkVal({tag, " bubble errors"}, 32'(bubbleBad), 32'd0);
    checkVal({tag, " stall low in DONE"}, 32'(stall_o), 32'd0);
  endtask

  initial begin
    vec_t nop;
    nop = mk(0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 4'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 4'b0);
    // {MemWr, MemRd, DataSrc, WrReg}
    vecs[0]  = mk(32'd5, 32'd7, 32'h20, 5'd3, 5'd1, 5'd2, 2'b10, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 0, 32'd12, 32'd7, 5'd3, 1'b0, 4'b0001);
    vecs[1]  = mk(32'd0, 32'd2, 32'h22, 5'd4, 5'd3, 5'd1, 2'b10, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 0, 32'd10, 32'd2, 5'd4, 1'b0, 4'b0001);
    vecs[2]  = mk(32'd5, 32'd7, 32'h20, 5'd0, 5'd5, 5'd6, 2'b10, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 0, 32'd12, 32'd7, 5'd0, 1'b0, 4'b0001);
    vecs[3]  = mk(32'd0, 32'd2, 32'h22, 5'd8, 5'd0, 5'd7, 2'b10, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 0, 32'hFFFF_FFFE, 32'd2, 5'd8, 1'b0, 4'b0001);
    vecs[4]  = mk(32'd0, 32'd0, 32'd9, 5'd0, 5'd0, 5'd3, 2'b00, 1'b1, 1'b0, 4'b0001, 1'b0, 5'd0, 0, 32'd9, 32'd0, 5'd3, 1'b0, 4'b0001);
    vecs[5]  = mk(32'd100, 32'd0, 32'd1, 5'd0, 5'd3, 5'd9, 2'b00, 1'b1, 1'b0, 4'b0001, 1'b1, 5'd3, 32'd4, 32'd10, 32'd0, 5'd9, 1'b0, 4'b0001);
    vecs[6]  = mk(32'd1, 32'd6, 32'h0F, 5'd0, 5'd5, 5'd10, 2'b11, 1'b1, 1'b0, 4'b0001, 1'b1, 5'd5, 32'd20, 32'h1F, 32'd6, 5'd10, 1'b0, 4'b0001);
    vecs[7]  = mk(32'd4, 32'd4, 32'h22, 5'd13, 5'd11, 5'd12, 2'b10, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 0, 32'd0, 32'd4, 5'd13, 1'b1, 4'b0001);
    vecs[8]  = mk(32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd16, 5'd14, 5'd15, 2'b10, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 0, 32'd1, 32'd1, 5'd16, 1'b0, 4'b0001);
    vecs[9]  = mk(32'h100, 32'h55, 32'd8, 5'd0, 5'd17, 5'd18, 2'b00, 1'b1, 1'b0, 4'b1000, 1'b1, 5'd18, 32'hCAFE, 32'h108, 32'hCAFE, 5'd18, 1'b0, 4'b1000);
    vecs[10] = mk(32'hF0F0, 32'h0FF0, 32'h24, 5'd21, 5'd19, 5'd20, 2'b10, 1'b0, 1'b1, 4'b0111, 1'b0, 5'd0, 0, 32'hF0, 32'h0FF0, 5'd21, 1'b0, 4'b0111);
    vecs[11] = mk(32'hF000, 32'h000F, 32'h25, 5'd22, 5'd21, 5'd2, 2'b10, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 0, 32'hFF, 32'h0F, 5'd22, 1'b0, 4'b0001);
    vecs[12] = mk(32'h100, 32'd5, 32'h22, 5'd23, 5'd2, 5'd22, 2'b10, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 0, 32'd1, 32'hFF, 5'd23, 1'b0, 4'b0001);
    vecs[13] = mk(32'd7, 32'd3, 32'h3F, 5'd24, 5'd1, 5'd2, 2'b10, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 0, 32'd0, 32'd3, 5'd24, 1'b1, 4'b0001);
    vecs[14] = mk(32'd1, 32'hFFFF_FFFF, 32'h2A, 5'd26, 5'd5, 5'd25, 2'b10, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 0, 32'd0, 32'hFFFF_FFFF, 5'd26, 1'b1, 4'b0001);

    rst = 1'b1;
    applyStimulus(nop);
    #12;
    checkOutput(nop, "reset");
    checkVal("reset stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkVal($sformatf("v%0d stall", i), 32'(stall_o), 32'd0);
      @(posedge clk); #1;
      checkOutput(vecs[i], $sformatf("v%0d", i));
    end

    // -3 * 7, followed immediately by 0x10000 * 0x10000
    applyStimulus(mk(32'hFFFF_FFFD, 32'd7, 32'h18, 5'd29, 5'd27, 5'd28, 2'b10, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 0, 0, 0, 0, 1'b0, 4'b0));
    #1;
    checkVal("mult1 stall at present", 32'(stall_o), 32'd1);
    runMult("mult1", 5'd27);
    applyStimulus(mk(32'h10000, 32'h10000, 32'h18, 5'd30, 5'd1, 5'd2, 2'b10, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 0, 0, 0, 0, 1'b0, 4'b0));
    @(posedge clk); #1;
    checkOutput(mk(0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 4'b0, 1'b0, 0, 0, 32'hFFFF_FFEB, 32'd7, 5'd29, 1'b0, 4'b0001), "mult1 result");
    checkVal("mult2 back-to-back stall", 32'(stall_o), 32'd1);
    runMult("mult2", 5'd1);
    applyStimulus(nop);
    @(posedge clk); #1;
    checkOutput(mk(0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 4'b0, 1'b0, 0, 0, 32'd0, 32'h10000, 5'd30, 1'b1, 4'b0001), "mult2 result");

    // Reset in the middle of a multiply, then a plain add
    applyStimulus(mk(32'd5, 32'd6, 32'h18, 5'd9, 5'd7, 5'd8, 2'b10, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 0, 0, 0, 0, 1'b0, 4'b0));
    repeat (11) @(posedge clk);
    #1;
    checkVal("mid-mult stall before reset", 32'(stall_o), 32'd1);
    rst = 1'b1;
    #1;
    checkVal("abort stall", 32'(stall_o), 32'd0);
    checkOutput(nop, "abort");
    applyStimulus(mk(32'd1, 32'd1, 32'h20, 5'd3, 5'd1, 5'd2, 2'b10, 1'b0, 1'b1, 4'b0001, 1'b0, 5'd0, 0, 0, 0, 0, 1'b0, 4'b0));
    #2;
    rst = 1'b0;
    #1;
    checkVal("post-reset stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    checkOutput(mk(0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 4'b0, 1'b0, 0, 0, 32'd2, 32'd1, 5'd3, 1'b0, 4'b0001), "post-reset add");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ex_stage_exmem.md
Name: ex_stage_exmem

Overview:
- Execute stage plus EX/MEM pipeline register of the 5-stage pipelined MIPS-subset core.
- Consumes the ID/EX register outputs and resolves RAW hazards by forwarding from EX/MEM (its own outputs) and MEM/WB.
- Computes the ALU result, including a 32-cycle iterative multiply that stalls the front end.
- Registers the results and MEM/WB control bits for the memory stage.

Parameters:
- W, 32, datapath width.
- MUL_CYC, 32, shift-add iterations per multiply; equals W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rg1  in  W  rs value from ID/EX
- rg2  in  W  rt value from ID/EX
- immVal  in  W  sign-extended immediate; bits [5:0] are funct for R-type
- destReg  in  5  rd field
- rdRg1  in  5  rs index
- rdRg2  in  5  rt index
- AluOp  in  2  00 add (lw/sw/addi), 01 sub, 10 R-type by funct, 11 or (ori)
- AluSrc  in  1  1: operand B = immVal
- RegDst  in  1  1: destination = destReg, 0: rdRg2
- MemWr, MemRd, DataSrc, WrReg  in  1 each  control bits passed to EX/MEM
- wb_wr  in  1  MEM/WB write enable
- wb_dst  in  5  MEM/WB destination
- wb_data  in  W  MEM/WB write-back data
- alu_res  out  W  EX/MEM ALU result
- st_data  out  W  EX/MEM store data (forwarded rt)
- dst  out  5  EX/MEM destination register
- zero  out  1  EX/MEM: alu_res == 0
- mem_wr, mem_rd, data_src, wr_reg  out  1 each  EX/MEM control bits
- stall_o  out  1  holds PC, IF/ID and ID/EX (combinational)

Behaviour:
- Reset: all outputs zero, FSM = IDLE, counter = 0.
- Forwarding for operand A (rs), evaluated independently for operand B source (rt):
  - if wr_reg && dst != 0 && dst == rs: use alu_res (EX/MEM);
  - else if wb_wr && wb_dst != 0 && wb_dst == rs: use wb_data;
  - else use rg1.
  - EX/MEM has priority over MEM/WB.
- Operand B = immVal when AluSrc = 1, else forwarded rt. st_data always takes forwarded rt.
- R-type funct decode:
  - 100000 add, 100010 sub, 100100 and, 100101 or
  - 101010 slt (signed, result 1 or 0)
  - 011000 mult (low W bits of the signed product)
  - any other funct: result 0
- Add/sub wrap modulo 2^W. No overflow trap.
- Destination = RegDst ? destReg : rdRg2.
- Normal ops have 1-cycle latency: EX/MEM loads result and controls on the next edge.
- FSM IDLE / MUL / DONE:
  - IDLE: if AluOp = 10 and funct = mult, capture forwarded A and B, clear accumulator, counter = 0, go to MUL.
  - MUL: one shift-add step per cycle. After step MUL_CYC-1, go to DONE.
  - DONE: EX/MEM loads the product with the mult's dst and controls, then go to IDLE.
- stall_o = (IDLE && mult present) || MUL. For a mult presented after edge 0, stall_o is high for 33 cycles and the product reaches alu_res at edge 34.
- While stall_o = 1, EX/MEM loads a bubble: all controls 0, data 0, dst 0. Operands are latched at capture, so the draining MEM/WB path does not corrupt them.
- Back-to-back mult: the second mult starts in IDLE right after DONE, with no extra idle cycle.
- Asserting rst mid-multiply aborts immediately: IDLE, stall_o = 0, outputs zero.
- Register 0 is never a forwarding source.

Test Plan:
- Add: rg1=5, rg2=7, AluOp=10, funct=100000, RegDst=1, destReg=3, WrReg=1 -> next edge alu_res=12, dst=3, wr_reg=1, zero=0.
- EX/MEM forwarding: add r3 gives 12, next instr sub r4=r3-r1 with rg1 stale=0, rdRg1=3, rg2=2 -> alu_res=10. Repeat with dst=0 -> no forward, alu_res=-2.
- Priority: EX/MEM dst=3 value 9 and wb_dst=3 wb_data=4, both writing; instr reads rs=3 with add imm 1 -> alu_res=10.
- Mult: A=-3, B=7, funct=011000 -> stall_o high edges 0..33, bubbles in EX/MEM, alu_res=0xFFFFFFEB at edge 34. 0x10000 * 0x10000 -> 0.
- Reset mid-mult: assert rst at cycle 10 of MUL -> stall_o=0 and all outputs 0 immediately. After release, add 1+1 gives 2 on the next edge.
- slt/zero: sub 4-4 -> zero=1. slt -1,1 -> alu_res=1. sw with MemWr=1, forwarded rt from MEM/WB -> st_data = wb_data.
